// File: rtl/pattern_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
// pattern_lock_ctrl_if : code-entry, configuration and status bundle
// Revision: 1.0
// ============================================================================
interface pattern_lock_ctrl_if #(
   parameter int CODE_W   = 8,
   parameter int MAX_FAIL = 3
);
   localparam int FAIL_W = $clog2(MAX_FAIL + 1);

   logic              in;
   logic              in_valid;
   logic              start;
   logic              Lock;
   logic              cfg_we;
   logic [CODE_W-1:0] cfg_code;
   logic              out;
   logic              Lock_out;
   logic              busy;
   logic              err;
   logic              cfg_ack;
   logic [FAIL_W-1:0] fail_cnt;

   modport master (
      output in, in_valid, start, Lock, cfg_we, cfg_code,
      input  out, Lock_out, busy, err, cfg_ack, fail_cnt
   );

   modport slave (
      input  in, in_valid, start, Lock, cfg_we, cfg_code,
      output out, Lock_out, busy, err, cfg_ack, fail_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pattern_lock_ctrl.sv
`default_nettype none
// ============================================================================
// pattern_lock_ctrl : serial pattern lock sequencer with retry lockout
// Revision: 1.0
// ============================================================================
module pattern_lock_ctrl #(
   parameter int                CODE_W       = 8,
   parameter logic [CODE_W-1:0] DEFAULT_CODE = 8'hD8,
   parameter int                MAX_FAIL     = 3,
   parameter int                OPEN_CYC     = 32,
   parameter int                LOCKOUT_CYC  = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   pattern_lock_ctrl_if.slave bus
);
   localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
   localparam int CNT_W   = $clog2(CODE_W + 1);
   localparam int TMR_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [2:0] ST_LOCKED  = 3'd0;
   localparam logic [2:0] ST_ENTRY   = 3'd1;
   localparam logic [2:0] ST_CHECK   = 3'd2;
   localparam logic [2:0] ST_OPEN    = 3'd3;
   localparam logic [2:0] ST_LOCKOUT = 3'd4;

   logic [2:0]        state_q,    state_d;
   logic [CODE_W-1:0] code_q,     code_d;
   logic [CODE_W-1:0] shreg_q,    shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
   logic [TMR_W-1:0]  timer_q,    timer_d;
   logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
   logic              err_q,      err_d;
   logic              cfg_ack_q,  cfg_ack_d;
   logic [FAIL_W-1:0] fail_inc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_LOCKED;
         code_q     <= DEFAULT_CODE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         timer_q    <= '0;
         fail_cnt_q <= '0;
         err_q      <= 1'b0;
         cfg_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         timer_q    <= timer_d;
         fail_cnt_q <= fail_cnt_d;
         err_q      <= err_d;
         cfg_ack_q  <= cfg_ack_d;
      end
   end

   // Saturating increment; reaching MAX_FAIL always diverts to lockout.
   assign fail_inc = (fail_cnt_q == FAIL_W'(MAX_FAIL)) ? fail_cnt_q
                                                       : fail_cnt_q + FAIL_W'(1);

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      timer_d    = timer_q;
      fail_cnt_d = fail_cnt_q;
      err_d      = 1'b0;
      cfg_ack_d  = 1'b0;
      case (state_q)
         ST_LOCKED: begin
            if (bus.start) begin
               state_d   = ST_ENTRY;
               shreg_d   = '0;
               bit_cnt_d = '0;
            end
         end
         ST_ENTRY: begin
            if (bus.Lock) begin
               state_d = ST_LOCKED;
            end else if (bus.start) begin
               shreg_d   = '0;
               bit_cnt_d = '0;
            end else if (bus.in_valid) begin
               shreg_d   = {shreg_q[CODE_W-2:0], bus.in};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_W'(CODE_W - 1)) begin
                  state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            timer_d = '0;
            if (shreg_q == code_q) begin
               state_d    = ST_OPEN;
               fail_cnt_d = '0;
            end else begin
               err_d      = 1'b1;
               fail_cnt_d = fail_inc;
               state_d    = (fail_inc == FAIL_W'(MAX_FAIL)) ? ST_LOCKOUT : ST_LOCKED;
            end
         end
         ST_OPEN: begin
            if (bus.Lock) begin
               state_d = ST_LOCKED;
               timer_d = '0;
            end else if (bus.cfg_we) begin
               // A code write re-arms the full open window.
               code_d    = bus.cfg_code;
               cfg_ack_d = 1'b1;
               timer_d   = '0;
            end else if (timer_q == TMR_W'(OPEN_CYC - 1)) begin
               state_d = ST_LOCKED;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_LOCKOUT: begin
            if (timer_q == TMR_W'(LOCKOUT_CYC - 1)) begin
               state_d    = ST_LOCKED;
               timer_d    = '0;
               fail_cnt_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = ST_LOCKED;
         end
      endcase
   end

   always_comb begin
      bus.out      = (state_q == ST_OPEN);
      bus.Lock_out = (state_q == ST_LOCKOUT);
      bus.busy     = (state_q == ST_ENTRY) || (state_q == ST_CHECK);
      bus.err      = err_q;
      bus.cfg_ack  = cfg_ack_q;
      bus.fail_cnt = fail_cnt_q;
   end
endmodule
`default_nettype wire

// File: tb/tb_pattern_lock_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pattern_lock_ctrl : directed vector table plus multi-cycle sequences
// Revision: 1.0
// ============================================================================
module tb_pattern_lock_ctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   pattern_lock_ctrl_if #(.CODE_W(8), .MAX_FAIL(3)) bus ();

   pattern_lock_ctrl #(
      .CODE_W(8), .DEFAULT_CODE(8'hD8), .MAX_FAIL(3), .OPEN_CYC(32), .LOCKOUT_CYC(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic       in_b;
      logic       iv;
      logic       st;
      logic       lk;
      logic       e_out;
      logic       e_lo;
      logic       e_busy;
      logic       e_err;
      logic [1:0] e_fail;
   } vec_t;

   vec_t vecs[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic in_b, iv, st, lk, e_out, e_lo, e_busy, e_err,
                       input logic [1:0] e_fail);
      vec_t v;
      v.in_b = in_b; v.iv = iv; v.st = st; v.lk = lk;
      v.e_out = e_out; v.e_lo = e_lo; v.e_busy = e_busy; v.e_err = e_err; v.e_fail = e_fail;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string name, input logic e_out, e_lo, e_busy, e_err, e_ack,
                           input logic [1:0] e_fail);
      chk({name, ".out"},      8'(bus.out),      8'(e_out));
      chk({name, ".Lock_out"}, 8'(bus.Lock_out), 8'(e_lo));
      chk({name, ".busy"},     8'(bus.busy),     8'(e_busy));
      chk({name, ".err"},      8'(bus.err),      8'(e_err));
      chk({name, ".cfg_ack"},  8'(bus.cfg_ack),  8'(e_ack));
      chk({name, ".fail_cnt"}, 8'(bus.fail_cnt), 8'(e_fail));
   endtask

   // Inputs are held from just after one rising edge to just after the next.
   task automatic drive(input logic in_b, iv, st, lk, we, input logic [7:0] code);
      bus.in = in_b; bus.in_valid = iv; bus.start = st; bus.Lock = lk;
      bus.cfg_we = we; bus.cfg_code = code;
      @(posedge clk);
      #1;
      bus.in = 1'b0; bus.in_valid = 1'b0; bus.start = 1'b0; bus.Lock = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_code = 8'h00;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic enter_code(input logic [7:0] code);
      logic [7:0] c;
      c = code;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 7; i >= 0; i--) drive(c[i], 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("entry_last_bit_busy", 8'(bus.busy), 8'd1);
   endtask

   initial begin
      logic [7:0] c00;
      logic [7:0] cd8;
      n_checks = 0;
      n_errors = 0;
      c00 = 8'h00;
      cd8 = 8'hD8;
      bus.in = 1'b0; bus.in_valid = 1'b0; bus.start = 1'b0; bus.Lock = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_code = 8'h00;

      // Failed attempt (00) then correct code (D8), one record per cycle.
      push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      for (int i = 7; i >= 0; i--) push(c00[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
      push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      for (int i = 7; i >= 0; i--) push(cd8[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].in_b, vecs[i].iv, vecs[i].st, vecs[i].lk, 1'b0, 8'h00);
         chk_outs($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_lo, vecs[i].e_busy,
                  vecs[i].e_err, 1'b0, vecs[i].e_fail);
      end

      // Open window: 32 cycles high in total, then relock.
      for (int i = 1; i < 32; i++) begin
         idle();
         chk("open_hold", 8'(bus.out), 8'd1);
      end
      idle();
      chk("open_expire", 8'(bus.out), 8'd0);

      // Three failures -> 16-cycle lockout that ignores all inputs.
      for (int a = 1; a <= 3; a++) begin
         enter_code(8'h00);
         idle();
         chk_outs($sformatf("fail%0d", a), 1'b0, (a == 3), 1'b0, 1'b1, 1'b0, 2'(a));
         if (a < 3) begin
            idle();
            chk("err_one_cycle", 8'(bus.err), 8'd0);
         end
      end
      for (int i = 1; i < 16; i++) begin
         if (i == 5) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C);
         else idle();
         chk_outs("lockout_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
      end
      idle();
      chk_outs("lockout_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      idle();
      chk("lockout_start_ignored", 8'(bus.busy), 8'd0);

      // Code write while open restarts the timer, then Lock relocks.
      enter_code(8'hD8);
      idle();
      chk("open_d8", 8'(bus.out), 8'd1);
      repeat (10) idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
      chk_outs("cfg_write", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      idle();
      chk("cfg_ack_pulse", 8'(bus.cfg_ack), 8'd0);
      repeat (24) idle();
      chk("open_restart", 8'(bus.out), 8'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("lock_relock", 8'(bus.out), 8'd0);
      enter_code(8'hD8);
      idle();
      chk_outs("old_code_rejected", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      enter_code(8'hA5);
      idle();
      chk_outs("new_code_opens", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // Asynchronous reset while open reverts the code register.
      repeat (3) idle();
      rst = 1'b0;
      #2;
      chk("async_reset_out", 8'(bus.out), 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      enter_code(8'hA5);
      idle();
      chk_outs("reset_code_a5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      enter_code(8'hD8);
      idle();
      chk_outs("reset_code_d8", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // Lock and cfg_we together: Lock wins, nothing written.
      idle();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
      chk_outs("lock_vs_we", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      idle();
      chk("lock_vs_we_noack", 8'(bus.cfg_ack), 8'd0);
      enter_code(8'h3C);
      idle();
      chk("code_3c_rejected", 8'(bus.err), 8'd1);
      enter_code(8'hD8);
      idle();
      chk_outs("code_d8_kept", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

      // Restart mid-entry discards partial bits; start beats in_valid.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 7; i >= 0; i--) drive(cd8[i], 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      idle();
      chk_outs("restart_entry", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

      // Lock mid-entry aborts silently, fail count preserved.
      enter_code(8'h00);
      idle();
      chk("pre_abort_fail", 8'(bus.fail_cnt), 8'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk_outs("abort_lock", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
      idle();
      chk_outs("abort_no_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pattern_lock_ctrl.md
Name: pattern_lock_ctrl

Overview:
Sequencing controller for the serial pattern lock. It frames one code-entry attempt, shifts in serial bits and compares them against a programmable code register. It tracks failed attempts, enforces a lockout after repeated failures, holds the unlocked state for a bounded time, and accepts new codes only while unlocked.

Parameters:
CODE_W, 8, code length in bits (>=2)
DEFAULT_CODE, 8'hD8, code register value after reset (bit sequence 1,1,0,1,1,0,0,0 MSB first)
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1)
OPEN_CYC, 32, cycles the lock stays open
LOCKOUT_CYC, 16, cycles of lockout

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
in  in  1  serial code bit
in_valid  in  1  in is valid this cycle
start  in  1  pulse: begin or restart an entry attempt
Lock  in  1  force relock / abort entry
cfg_we  in  1  request to write cfg_code into the code register
cfg_code  in  CODE_W  new code
out  out  1  unlocked indicator
Lock_out  out  1  lockout active
busy  out  1  entry in progress
err  out  1  one-cycle pulse on a failed attempt
cfg_ack  out  1  one-cycle pulse when a code write is accepted
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failure count

Behaviour:
- Reset (rst=0, asynchronous): state LOCKED; code_reg=DEFAULT_CODE; shreg, bit_cnt, timer, fail_cnt=0; all outputs 0. A reset mid-operation aborts it and reverts code_reg.
- States: LOCKED, ENTRY, CHECK, OPEN, LOCKOUT. out=(OPEN), Lock_out=(LOCKOUT), busy=(ENTRY|CHECK) are decoded from the state register. err and cfg_ack are registered pulses.
- LOCKED: start -> ENTRY, clear shreg and bit_cnt. in_valid is ignored, including in the same cycle as start. cfg_we is ignored.
- ENTRY:
  - Each in_valid: shreg <= {shreg[CODE_W-2:0], in}; bit_cnt++.
  - On the edge accepting the CODE_W-th bit -> CHECK.
  - start (priority over in_valid): clear shreg and bit_cnt, stay in ENTRY, discard the bit.
  - Lock (priority over start): -> LOCKED, fail_cnt unchanged, no err.
- CHECK: exactly one cycle; Lock and start are ignored.
  - shreg==code_reg -> OPEN; fail_cnt<=0; timer<=0.
  - Mismatch: err=1 on the next cycle; fail_cnt+1. If the new value==MAX_FAIL -> LOCKOUT (timer<=0), else -> LOCKED.
- Latency: last bit accepted at edge N; CHECK during N..N+1; out (or err) high after edge N+1.
- OPEN:
  - out stays high exactly OPEN_CYC cycles, then -> LOCKED.
  - Lock -> LOCKED on the next edge.
  - cfg_we (no Lock): code_reg<=cfg_code; cfg_ack high the following cycle; timer restarts at 0.
  - Lock and cfg_we together: Lock wins, no write, no ack.
  - start and in_valid are ignored.
- LOCKOUT: Lock_out high exactly LOCKOUT_CYC cycles, then -> LOCKED with fail_cnt<=0. start, in, Lock and cfg_we are all ignored.
- fail_cnt saturates at MAX_FAIL and clears only on success, lockout expiry or reset.
- Timers count from 0 to limit-1, and the transition occurs on the edge at limit-1. No wrap or overflow occurs in any other state.

Test Plan:
1. Reset, start, then bits 1,1,0,1,1,0,0,0 on consecutive cycles -> busy=1 for 9 cycles; out=1 two edges after the last bit, for exactly 32 cycles; fail_cnt=0.
2. Three attempts with 8'h00 -> err pulses after each attempt; fail_cnt 1,2,then 3; Lock_out=1 for exactly 16 cycles. A start during lockout is ignored. Afterwards state is LOCKED with fail_cnt=0.
3. Open with 8'hD8, cfg_we with cfg_code=8'hA5 -> cfg_ack for one cycle and the open timer restarts (32 cycles from the write). Pulse Lock -> out=0. Entry of D8 then gives err; entry of A5 gives out=1.
4. start, bits 1,0,1,0, start again, then D8 bits -> the first 4 bits are discarded and out=1. In a separate run, Lock mid-entry -> LOCKED with no err and fail_cnt unchanged.
5. After writing 8'hA5, drop rst while out=1 -> out=0 immediately (asynchronous). After release, code_reg=D8: entering A5 fails, entering D8 opens.
6. In OPEN, assert Lock and cfg_we (8'h3C) in the same cycle -> LOCKED, no cfg_ack, code unchanged (D8 still opens).
